// File: rtl/mult_div_if.sv
// Operand/control/result bundle between the execute stage and the mult_div core.
// Latency: none (wires only).
// Backpressure: none; ctrl_MULT/ctrl_DIV are fire-and-forget start pulses.
//
// Signals:
//   data_operandA  [31:0]  multiplicand / dividend (signed)
//   data_operandB  [31:0]  multiplier / divisor (signed)
//   ctrl_MULT              start-multiply pulse
//   ctrl_DIV               start-divide pulse
//   data_result    [31:0]  low product word or quotient
//   data_exception         multiply overflow or divide-by-zero
//   data_resultRDY         one-cycle result-valid pulse
// Modports: master drives operands/controls, slave (the core) drives results.
interface mult_div_if;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;

   modport master (
      output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      input  data_result, data_exception, data_resultRDY
   );

   modport slave (
      input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      output data_result, data_exception, data_resultRDY
   );
endinterface

// File: rtl/mult_div.sv
// Iterative 32-bit signed multiplier (radix-2 Booth) / divider (restoring) on one shared datapath.
// Latency: start edge N -> data_resultRDY high in the cycle after edge N+33 (divide-by-zero: N+1 with MULTDIV_EARLY_DIV0_EN).
// Backpressure: none; a new start in any state aborts the running operation and restarts.
//
// Ports:
//   clock   rising-edge clock for all state
//   reset   synchronous, active-high
//   bus     mult_div_if.slave: operands, start pulses, result/exception/ready
// Build option: define MULTDIV_EARLY_DIV0_EN to finish a divide by zero one cycle after its start.
module mult_div (
   input  logic      clock,
   input  logic      reset,
   mult_div_if.slave bus
);

   typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

   state_t      state;
   logic [63:0] acc;        // MULT: {partial hi, multiplier lo}; DIV: {remainder, dividend/quotient}
   logic [31:0] opnd;       // MULT: multiplicand; DIV: divisor magnitude
   logic [5:0]  count;
   logic        booth_q1;   // Booth's implicit bit to the right of the multiplier
   logic        op_div;
   logic        q_neg;
   logic        div_zero;

   logic        start;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [32:0] booth_sum;
   logic [63:0] div_shift;
   logic [32:0] div_trial;
   logic [31:0] quot_signed;
   logic        mult_ovf;

   always_comb begin
      start = bus.ctrl_MULT | bus.ctrl_DIV;

      // Negating 0x80000000 yields 0x80000000, which is exactly 2^31 read as unsigned.
      mag_a = bus.data_operandA[31] ? (~bus.data_operandA + 32'd1) : bus.data_operandA;
      mag_b = bus.data_operandB[31] ? (~bus.data_operandB + 32'd1) : bus.data_operandB;

      // One guard bit keeps the add/sub exact when the multiplicand is -2^31.
      booth_sum = {acc[63], acc[63:32]};
      case ({acc[0], booth_q1})
         2'b01:   booth_sum = {acc[63], acc[63:32]} + {opnd[31], opnd};
         2'b10:   booth_sum = {acc[63], acc[63:32]} - {opnd[31], opnd};
         default: booth_sum = {acc[63], acc[63:32]};
      endcase

      // Remainder stays below the divisor (<= 2^31), so the shifted value fits in 32 bits.
      div_shift = {acc[62:0], 1'b0};
      div_trial = {1'b0, div_shift[63:32]} - {1'b0, opnd};

      quot_signed = q_neg ? (~acc[31:0] + 32'd1) : acc[31:0];
      mult_ovf    = ~((&acc[63:31]) | ~(|acc[63:31]));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state              <= IDLE;
         acc                <= 64'd0;
         opnd               <= 32'd0;
         count              <= 6'd0;
         booth_q1           <= 1'b0;
         op_div             <= 1'b0;
         q_neg              <= 1'b0;
         div_zero           <= 1'b0;
         bus.data_result    <= 32'd0;
         bus.data_exception <= 1'b0;
         bus.data_resultRDY <= 1'b0;
      end else begin
         bus.data_resultRDY <= 1'b0;
         if (start) begin
            count    <= 6'd0;
            booth_q1 <= 1'b0;
            if (bus.ctrl_MULT) begin
               state  <= MULT;
               op_div <= 1'b0;
               acc    <= {32'd0, bus.data_operandA};
               opnd   <= bus.data_operandB;
            end else begin
               state    <= DIV;
               op_div   <= 1'b1;
               acc      <= {32'd0, mag_a};
               opnd     <= mag_b;
               q_neg    <= bus.data_operandA[31] ^ bus.data_operandB[31];
               div_zero <= (bus.data_operandB == 32'd0);
`ifdef MULTDIV_EARLY_DIV0_EN
               if (bus.data_operandB == 32'd0) begin
                  state <= DONE;
               end
`endif
            end
         end else begin
            case (state)
               IDLE: begin
               end
               MULT: begin
                  // Arithmetic right shift of {sum, multiplier} by one.
                  acc      <= {booth_sum[32:1], booth_sum[0], acc[31:1]};
                  booth_q1 <= acc[0];
                  count    <= count + 6'd1;
                  if (count == 6'd31) begin
                     state <= DONE;
                  end
               end
               DIV: begin
                  if (!div_trial[32]) begin
                     acc <= {div_trial[31:0], div_shift[31:0] | 32'd1};
                  end else begin
                     acc <= div_shift;
                  end
                  count <= count + 6'd1;
                  if (count == 6'd31) begin
                     state <= DONE;
                  end
               end
               DONE: begin
                  state              <= IDLE;
                  bus.data_resultRDY <= 1'b1;
                  if (op_div) begin
                     bus.data_result    <= div_zero ? 32'd0 : quot_signed;
                     bus.data_exception <= div_zero;
                  end else begin
                     bus.data_result    <= acc[31:0];
                     bus.data_exception <= mult_ovf;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div: directed vector table, hand-written corner
// sequences (reset, abort/restart) and randomized operations checked against an
// arithmetic reference model.
module tb_mult_div;

   logic clock;
   logic reset;
   int   n_checks;
   int   n_errors;

   mult_div_if bus ();

   mult_div dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

`ifdef MULTDIV_EARLY_DIV0_EN
   localparam int DIV0_LAT = 1;
`else
   localparam int DIV0_LAT = 33;
`endif
   localparam longint MAX_I32 = 64'sd2147483647;
   localparam longint MIN_I32 = -64'sd2147483648;

   typedef struct {
      logic        m;
      logic        d;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_r;
      logic        exp_e;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: exact 64-bit signed arithmetic; division truncates toward zero.
   function automatic void ref_op(input logic m, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
      longint sa;
      longint sb;
      longint p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      if (m) begin
         p = sa * sb;
         r = p[31:0];
         e = (p > MAX_I32) || (p < MIN_I32);
      end else if (b == 32'd0) begin
         r = 32'd0;
         e = 1'b1;
      end else begin
         p = sa / sb;
         r = p[31:0];
         e = 1'b0;
      end
   endfunction

   // Issue one start pulse, scramble operands afterwards, wait (bounded) for RDY.
   task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic e, output int lat);
      @(negedge clock);
      bus.ctrl_MULT     = m;
      bus.ctrl_DIV      = d;
      bus.data_operandA = a;
      bus.data_operandB = b;
      @(posedge clock);
      #1;
      bus.ctrl_MULT     = 1'b0;
      bus.ctrl_DIV      = 1'b0;
      bus.data_operandA = $urandom;
      bus.data_operandB = $urandom;
      lat = -1;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clock);
         #1;
         if (bus.data_resultRDY) begin
            lat = c;
            break;
         end
      end
      r = bus.data_result;
      e = bus.data_exception;
      if (lat != -1) begin
         @(posedge clock);
         #1;
         check("rdy_one_cycle", {31'd0, bus.data_resultRDY}, 32'd0);
      end
   endtask

   initial begin
      vec_t        vecs[$];
      logic [31:0] r;
      logic        e;
      int          lat;
      int          rdy_cnt;
      int          exp_lat;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] er;
      logic        ee;
      logic        rm;

      n_checks = 0;
      n_errors = 0;
      reset = 1'b1;
      bus.ctrl_MULT     = 1'b0;
      bus.ctrl_DIV      = 1'b0;
      bus.data_operandA = 32'd0;
      bus.data_operandB = 32'd0;

      // Reset state and idle quiet period.
      repeat (2) @(posedge clock);
      #1;
      check("reset_result", bus.data_result, 32'd0);
      check("reset_exception", {31'd0, bus.data_exception}, 32'd0);
      check("reset_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      rdy_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clock);
         #1;
         if (bus.data_resultRDY) rdy_cnt++;
      end
      check("idle_no_rdy", rdy_cnt, 32'd0);

      // Directed vectors: {mult, div, A, B, result, exception}.
      vecs.push_back('{1'b0, 1'b1, 32'd3,          32'd0,          32'h00000000, 1'b1});
      vecs.push_back('{1'b1, 1'b0, -32'sd7,        32'd6,          32'hFFFFFFD6, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 32'h00010000,   32'h00010000,   32'h00000000, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF, 1'b0});
      vecs.push_back('{1'b0, 1'b1, -32'sd100,      32'd7,          32'hFFFFFFF2, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 32'h80000000,   32'd1,          32'h80000000, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 32'd7,          -32'sd2,        32'hFFFFFFFD, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 32'hFFFF0000,   32'h00008000,   32'h80000000, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 32'd3,          32'd4,          32'h0000000C, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 32'd0,          -32'sd5,        32'h00000000, 1'b0});

      foreach (vecs[i]) begin
         run_op(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b, r, e, lat);
         exp_lat = (!vecs[i].m && vecs[i].b == 32'd0) ? DIV0_LAT : 33;
         check($sformatf("vec%0d_result", i), r, vecs[i].exp_r);
         check($sformatf("vec%0d_exception", i), {31'd0, e}, {31'd0, vecs[i].exp_e});
         check($sformatf("vec%0d_latency", i), lat, exp_lat);
      end

      // Outputs hold between RDY pulses (last vector left 0/0; run a nonzero one first).
      run_op(1'b1, 1'b0, 32'd9, 32'd9, r, e, lat);
      repeat (5) @(posedge clock);
      #1;
      check("hold_result", bus.data_result, 32'd81);

      // Reset mid-operation: outputs clear, no RDY follows.
      @(negedge clock);
      bus.ctrl_DIV = 1'b1;
      bus.data_operandA = 32'd20;
      bus.data_operandB = 32'd3;
      @(posedge clock);
      #1;
      bus.ctrl_DIV = 1'b0;
      repeat (10) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("midreset_result", bus.data_result, 32'd0);
      rdy_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clock);
         #1;
         if (bus.data_resultRDY) rdy_cnt++;
      end
      check("midreset_no_rdy", rdy_cnt, 32'd0);

      // DIV 20/3 restarted by MULT 5*5 ten cycles in: one RDY, 33 edges after restart.
      @(negedge clock);
      bus.ctrl_DIV = 1'b1;
      bus.data_operandA = 32'd20;
      bus.data_operandB = 32'd3;
      @(posedge clock);
      #1;
      bus.ctrl_DIV = 1'b0;
      rdy_cnt = 0;
      for (int c = 0; c < 9; c++) begin
         @(posedge clock);
         #1;
         if (bus.data_resultRDY) rdy_cnt++;
      end
      @(negedge clock);
      bus.ctrl_MULT = 1'b1;
      bus.data_operandA = 32'd5;
      bus.data_operandB = 32'd5;
      @(posedge clock);
      #1;
      bus.ctrl_MULT = 1'b0;
      bus.data_operandA = 32'd1234;
      lat = -1;
      r = 32'd0;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clock);
         #1;
         if (bus.data_resultRDY) begin
            rdy_cnt++;
            if (lat == -1) begin
               lat = c;
               r = bus.data_result;
            end
         end
      end
      check("restart_rdy_count", rdy_cnt, 32'd1);
      check("restart_latency", lat, 32'd33);
      check("restart_result", r, 32'd25);

      // Randomized operations against the reference model.
      for (int i = 0; i < 40; i++) begin
         rm = $urandom_range(0, 1);
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
         if ($urandom_range(0, 3) == 0) rb = {{16{rb[15]}}, rb[15:0]};
         ref_op(rm, ra, rb, er, ee);
         run_op(rm, !rm, ra, rb, r, e, lat);
         exp_lat = (!rm && rb == 32'd0) ? DIV0_LAT : 33;
         check($sformatf("rand%0d_result", i), r, er);
         check($sformatf("rand%0d_exception", i), {31'd0, e}, {31'd0, ee});
         check($sformatf("rand%0d_latency", i), lat, exp_lat);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
